// File: rtl/scale_pkg.sv
// Purpose : shared defaults for the scale/round/saturate stage and the multiplier ahead of it.
// Latency : n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: default bus widths, fraction bits, frame geometry, pixel_t, cnt_width().
package scale_pkg;

  localparam int SCALE_DIN_WIDTH  = 32;   // signed product width from the multiplier
  localparam int SCALE_DOUT_WIDTH = 8;    // unsigned pixel width
  localparam int SCALE_FRAC_BITS  = 8;    // fixed-point fraction bits removed here
  localparam int SCALE_IMG_W      = 640;  // pixels per line
  localparam int SCALE_IMG_H      = 480;  // lines per frame

  typedef logic [SCALE_DOUT_WIDTH-1:0] pixel_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scale_pos_cnt.sv
// Purpose : column/row position of the pixel currently presented on the output.
// Latency : counters move on the edge where step=1; sof/eol are decoded from registers.
// Backpressure: none of its own; the caller only pulses step on a real output transfer.
// Ports   : clk, reset (async active-low), step -> col, row, sof (col=0,row=0), eol (col=IMG_W-1).
module scale_pos_cnt
  import scale_pkg::*;
#(
  parameter int IMG_W = SCALE_IMG_W,
  parameter int IMG_H = SCALE_IMG_H,
  localparam int COL_W = cnt_width(IMG_W),
  localparam int ROW_W = cnt_width(IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             sof,
  output logic             eol
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (step) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign col = r_col;
  assign row = r_row;
  assign sof = (r_col == '0) && (r_row == '0);
  assign eol = (r_col == COL_LAST);

endmodule

// File: rtl/scale_round_sat.sv
// Purpose : round a signed fixed-point product to nearest, drop FRAC_BITS, clamp to an unsigned pixel.
// Latency : 2 cycles from acceptance to out_valid, 1 pixel per cycle.
// Backpressure: whole pipe advances only when ce=1 and the output slot is empty or being taken;
//           in_ready is that advance term, so out_ready reaches in_ready combinationally.
// Ports   : clk, reset (async active-low), ce, in_data/in_valid/in_ready,
//           out_data/out_valid/out_ready, out_sof/out_eol (qualified by out_valid),
//           sat_cnt (clamped pixels in last completed frame; only with SCALE_SAT_CNT_EN).
// Macro   : SCALE_SAT_CNT_EN enables the per-frame saturation counter and the sat_cnt port.
// Assumes DOUT_WIDTH < DIN_WIDTH and 1 <= FRAC_BITS <= DIN_WIDTH-2.
module scale_round_sat
  import scale_pkg::*;
#(
  parameter int DIN_WIDTH  = SCALE_DIN_WIDTH,
  parameter int DOUT_WIDTH = SCALE_DOUT_WIDTH,
  parameter int FRAC_BITS  = SCALE_FRAC_BITS,
  parameter int IMG_W      = SCALE_IMG_W,
  parameter int IMG_H      = SCALE_IMG_H
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DIN_WIDTH-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DOUT_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eol
`ifdef SCALE_SAT_CNT_EN
  ,
  output logic [15:0]           sat_cnt
`endif
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);

  // Half an output LSB, added before truncation for round-half-up.
  localparam logic signed [DIN_WIDTH:0] RND = {{DIN_WIDTH{1'b0}}, 1'b1} <<< (FRAC_BITS - 1);

  logic                        w_adv;
  logic                        w_xfer;
  logic                        r_s1_vld;
  logic signed [DIN_WIDTH:0]   r_s1_sum;
  logic signed [DIN_WIDTH:0]   w_shift;
  logic                        w_neg;
  logic                        w_ovf;
  logic [DOUT_WIDTH-1:0]       w_pix;
  logic [COL_W-1:0]            w_col;
  logic [ROW_W-1:0]            w_row;
  logic                        w_sof;
  logic                        w_eol;
  logic                        w_unused_pos;

  assign w_adv    = ce & (~out_valid | out_ready);
  assign in_ready = w_adv;
  // ce gates the transfer too: with ce=0 the output is frozen, so nothing may be counted.
  assign w_xfer   = ce & out_valid & out_ready;

  // Stage 1: one extra bit of headroom so the rounding add can never overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s1_sum <= '0;
    end else if (w_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_sum <= $signed({in_data[DIN_WIDTH-1], in_data}) + RND;
      end
    end
  end

  // Stage 2 combinational: arithmetic shift, then clamp to [0, 2^DOUT_WIDTH-1].
  assign w_shift = r_s1_sum >>> FRAC_BITS;
  assign w_neg   = w_shift[DIN_WIDTH];
  assign w_ovf   = ~w_neg & (|w_shift[DIN_WIDTH-1:DOUT_WIDTH]);
  assign w_pix   = w_neg ? '0 : (w_ovf ? '1 : w_shift[DOUT_WIDTH-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (w_adv) begin
      out_valid <= r_s1_vld;
      if (r_s1_vld) begin
        out_data <= w_pix;
      end
    end
  end

  scale_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos_cnt (
    .clk   (clk),
    .reset (reset),
    .step  (w_xfer),
    .col   (w_col),
    .row   (w_row),
    .sof   (w_sof),
    .eol   (w_eol)
  );

  // Position decodes are only meaningful alongside a valid pixel (and col=row=0 in reset).
  assign out_sof = out_valid & w_sof;
  assign out_eol = out_valid & w_eol;

  // Raw position is not needed outside the counter in every build.
  assign w_unused_pos = ^{w_col, w_row};

`ifdef SCALE_SAT_CNT_EN
  logic        r_s1_neg;
  logic        r_s2_clamp;
  logic [15:0] r_sat_acc;
  logic [15:0] r_sat_cnt;
  logic [15:0] w_acc_next;
  logic        w_eof;

  // A negative product always lands on 0 and counts as clamped, even when rounding
  // alone would already have produced 0 (e.g. -5 with FRAC_BITS=8).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_neg <= 1'b0;
    end else if (w_adv && in_valid) begin
      r_s1_neg <= in_data[DIN_WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_clamp <= 1'b0;
    end else if (w_adv && r_s1_vld) begin
      r_s2_clamp <= r_s1_neg | w_ovf;
    end
  end

  assign w_acc_next = (r_s2_clamp && (r_sat_acc != 16'hFFFF)) ? r_sat_acc + 16'd1 : r_sat_acc;
  assign w_eof      = w_eol && (w_row == ROW_W'(IMG_H - 1));

  // The frame total published includes the final pixel of the frame itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_acc <= '0;
      r_sat_cnt <= '0;
    end else if (w_xfer) begin
      if (w_eof) begin
        r_sat_cnt <= w_acc_next;
        r_sat_acc <= '0;
      end else begin
        r_sat_acc <= w_acc_next;
      end
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_scale_round_sat.sv
// Purpose : directed self-checking bench for scale_round_sat on a 4x2 frame.
// Latency : n/a.
// Backpressure: exercised with out_ready stalls and ce freezes.
module tb_scale_round_sat;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
`ifdef SCALE_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  scale_round_sat #(
    .DIN_WIDTH  (32),
    .DOUT_WIDTH (8),
    .FRAC_BITS  (8),
    .IMG_W      (4),
    .IMG_H      (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
`ifdef SCALE_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic [7:0] d, input logic sof, input logic eol);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_dat"}, {24'd0, out_data}, {24'd0, d});
    check({tag, "_sof"}, {31'd0, out_sof}, {31'd0, sof});
    check({tag, "_eol"}, {31'd0, out_eol}, {31'd0, eol});
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_dat", {24'd0, out_data}, 32'd0);
    check("rst_sof", {31'd0, out_sof}, 32'd0);
    check("rst_eol", {31'd0, out_eol}, 32'd0);
    step();
    step();
    check("rst_hold_vld", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    step();

    // Rounding: 384 -> 2, 383 -> 1, output two edges after each acceptance.
    in_valid = 1'b1;
    in_data  = 32'd384;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("lat1_vld", {31'd0, out_valid}, 32'd0);
    in_data = 32'd383;
    step();
    chk_px("p1", 8'd2, 1'b1, 1'b0);
    in_data = -32'sd5;
    step();
    chk_px("p2", 8'd1, 1'b0, 1'b0);
    in_data = 32'd65536;
    step();
    chk_px("p3", 8'd0, 1'b0, 1'b0);
    in_data = 32'h7FFF_FFFF;
    step();
    chk_px("p4", 8'd255, 1'b0, 1'b1);

    // Output stall for 5 cycles: p4 must hold, nothing accepted.
    in_data   = 32'd25600;
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_px("stall_p4", 8'd255, 1'b0, 1'b1);
      check("stall_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk_px("p5", 8'd255, 1'b0, 1'b0);

    // ce low for 3 cycles: everything frozen, then resumes.
    in_data = 32'd51200;
    ce      = 1'b0;
    #1;
    check("ce0_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_px("ce0_p5", 8'd255, 1'b0, 1'b0);
    end
    ce = 1'b1;
    step();
    chk_px("p6", 8'd100, 1'b0, 1'b0);
    in_data = 32'd1000;
    step();
    chk_px("p7", 8'd200, 1'b0, 1'b0);
    in_data = 32'd127;
    step();
    chk_px("p8", 8'd4, 1'b0, 1'b1);
    in_data = 32'd128;
    step();
    chk_px("p9", 8'd0, 1'b1, 1'b0);
`ifdef SCALE_SAT_CNT_EN
    check("sat_cnt_frame", {16'd0, sat_cnt}, 32'd3);
`endif
    in_data = 32'd12800;
    step();
    chk_px("p10", 8'd1, 1'b0, 1'b0);

    // Reset mid-frame with a pixel in flight.
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    check("mid_rst_dat", {24'd0, out_data}, 32'd0);
    check("mid_rst_sof", {31'd0, out_sof}, 32'd0);
`ifdef SCALE_SAT_CNT_EN
    check("mid_rst_sat", {16'd0, sat_cnt}, 32'd0);
`endif
    step();
    reset = 1'b1;
    step();
    check("post_rst_flush", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'd768;
    step();
    in_valid = 1'b0;
    check("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    step();
    chk_px("post_rst_p1", 8'd3, 1'b1, 1'b0);
    step();
    check("bubble_vld", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scale_round_sat.md
SCALE_ROUND_SAT -- requirements
Module: scale_round_sat

Interface
REQ-001 The module SHALL have parameter DIN_WIDTH, default 32, the signed product width from the upstream multiplier.
REQ-002 The module SHALL have parameter DOUT_WIDTH, default 8, the unsigned pixel width.
REQ-003 The module SHALL have parameter FRAC_BITS, default 8, the fixed-point fraction bits to remove; legal range is 1..DIN_WIDTH-2.
REQ-004 The module SHALL have parameters IMG_W, default 640, and IMG_H, default 480, the pixels per line and lines per frame.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port ce, input, 1 bit: global pipeline enable.
REQ-008 The module SHALL have port in_data, input, DIN_WIDTH bits: signed product.
REQ-009 The module SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the input handshake.
REQ-010 The module SHALL have port out_data, output, DOUT_WIDTH bits: rounded, saturated pixel.
REQ-011 The module SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the output handshake.
REQ-012 The module SHALL have ports out_sof and out_eol, output, 1 bit each, qualified by out_valid: first pixel of frame, last pixel of line.
REQ-013 The module SHALL have port sat_cnt, output, 16 bits: saturation count of the last completed frame (present only with SCALE_SAT_CNT_EN).

Function
REQ-014 The pipeline SHALL advance (adv) only when ce=1 and (out_valid=0 or out_ready=1); in_ready SHALL equal adv, which is a combinational path from out_ready to in_ready.
REQ-015 An input is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-016 Stage 1 SHALL register the sum in_data + 2^(FRAC_BITS-1) at DIN_WIDTH+1 bits, signed, with no overflow.
REQ-017 Stage 2 SHALL arithmetic-shift the stage-1 value right by FRAC_BITS, clamp negatives to 0 and values above 2^DOUT_WIDTH-1 to 2^DOUT_WIDTH-1, and register the result to out_data.
REQ-018 Latency SHALL be 2 cycles from acceptance to out_valid=1 when unstalled; throughput SHALL be 1 per cycle.
REQ-019 When adv=0, all stage registers, valid bits and out_* SHALL hold.
REQ-020 Bubbles SHALL propagate: stage valid bits advance with adv even when in_valid=0.
REQ-021 The column counter SHALL increment per output transfer (out_valid and out_ready); at IMG_W-1 it SHALL wrap to 0 and increment the row counter, which wraps at IMG_H-1.
REQ-022 out_sof SHALL be 1 when col=0 and row=0; out_eol SHALL be 1 when col=IMG_W-1.
REQ-023 Stall cycles SHALL NOT change the counters; when ce=0 nothing changes.

Reset
REQ-024 Reset low SHALL immediately clear the valid bits, out_data, col, row and the saturation counters to 0; out_valid=0, out_sof=0, out_eol=0.
REQ-025 In-flight data SHALL be discarded on reset; the first post-reset output SHALL carry out_sof=1.
REQ-026 The reset release SHALL be synchronised externally; the block SHALL NOT add a synchroniser.

Configuration
REQ-027 With macro SCALE_SAT_CNT_EN defined, a 16-bit per-frame counter SHALL count transferred pixels that were clamped, stopping at 0xFFFF.
REQ-028 With SCALE_SAT_CNT_EN defined, at each transfer with out_eol=1 on the last row, the counter value including that pixel SHALL be copied to sat_cnt and the counter SHALL be cleared.
REQ-029 Without SCALE_SAT_CNT_EN, the sat_cnt port, the counter and the clamp flag SHALL be absent.

Structure
REQ-030 Package scale_pkg SHALL hold the default widths, FRAC_BITS, the IMG_W/IMG_H defaults and the pixel typedef, shared with the multiplier stage.
REQ-031 The position counters SHALL be sub-module scale_pos_cnt (inputs: clk, reset, step; outputs: col, row, sof, eol).

Verification
REQ-032 With FRAC_BITS=8 and in_data 384 then 383, out_data SHALL be 2 then 1, two cycles after each acceptance.
REQ-033 in_data -5, 65536 and 0x7FFFFFFF SHALL produce out_data 0, 255 and 255; with SCALE_SAT_CNT_EN, 3 clamps SHALL be counted.
REQ-034 With IMG_W=4 and IMG_H=2, streaming 9 pixels SHALL assert out_eol on pixels 4 and 8 and out_sof on pixels 1 and 9; with SCALE_SAT_CNT_EN, sat_cnt SHALL update after pixel 8.
REQ-035 Holding out_ready=0 for 5 cycles mid-stream SHALL drop in_ready, hold out_data, lose and duplicate nothing, and leave the counters unchanged.
REQ-036 Holding ce=0 for 3 cycles SHALL freeze all state, and output SHALL resume identically afterwards.
REQ-037 Asserting reset low mid-frame SHALL force out_valid=0 immediately, and the next output SHALL carry out_sof=1.
